// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the CPU/DMA memory-port arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_CPU  = 2'd1;
  localparam logic [1:0] ARB_DMA  = 2'd2;

  localparam int WORD_SIZE   = 16;
  localparam int TIMER_WIDTH = 8;
  localparam int NUM_REQ     = 2;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // Alternating priority: on contention the requester that did not own the port last wins.
  function automatic logic pick_dma(input logic cpu_elig, input logic dma_elig, input logic owner);
    return dma_elig & (~cpu_elig | (owner == OWNER_CPU));
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_timer.sv
// Saturating access-cycle counter; tc flags that TIMEOUT cycles have elapsed since clear.
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tc
);

  localparam logic [TIMER_WIDTH-1:0] TC_VALUE = TIMER_WIDTH'(TIMEOUT);

  logic [TIMER_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_reg != TC_VALUE) begin
      count_reg <= count_reg + TIMER_WIDTH'(1);
    end
  end

  assign tc = (count_reg == TC_VALUE);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU memory path and a DMA requester with
// alternating priority, wait-state tolerance and a timeout watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = WORD_SIZE,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  owner
);

  logic [1:0]            state_reg;
  logic                  owner_reg;
  logic                  mem_en_reg;
  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_wdata_reg;
  logic                  err_reg;

  logic cpu_elig;
  logic dma_elig;
  logic grant_dma;
  logic busy;
  logic finish;
  logic timer_clear;
  logic timer_tc;

  assign busy        = (state_reg != ARB_IDLE);
  // A requester is masked in its own ack cycle so a held req cannot be regranted.
  assign cpu_elig    = cpu_req & ~cpu_ack;
  assign dma_elig    = dma_req & ~dma_ack;
  assign grant_dma   = pick_dma(cpu_elig, dma_elig, owner_reg);
  assign finish      = busy & (mem_ready | timer_tc);
  assign timer_clear = ~busy;

  arb_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .tc     (timer_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= OWNER_DMA;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= finish & ~mem_ready;
      case (state_reg)
        ARB_IDLE: begin
          if (cpu_elig || dma_elig) begin
            owner_reg     <= grant_dma;
            mem_en_reg    <= 1'b1;
            state_reg     <= grant_dma ? ARB_DMA : ARB_CPU;
            mem_addr_reg  <= grant_dma ? dma_addr : cpu_addr;
            mem_we_reg    <= grant_dma ? dma_we : cpu_we;
            mem_wdata_reg <= grant_dma ? dma_wdata : cpu_wdata;
          end
        end
        ARB_CPU, ARB_DMA: begin
          if (finish) begin
            state_reg  <= ARB_IDLE;
            mem_en_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ARB_IDLE;
          mem_en_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester ack pulse and read-data holding register; index 0 is CPU, 1 is DMA.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
    localparam logic ID = (gi == 1) ? OWNER_DMA : OWNER_CPU;

    logic                  ack_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  mine;

    assign mine = busy & (owner_reg == ID);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ack_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= mine & finish;
        if (mine && mem_ready && !mem_we_reg) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign cpu_ack   = g_chan[0].ack_reg;
  assign cpu_rdata = g_chan[0].rdata_reg;
  assign dma_ack   = g_chan[1].ack_reg;
  assign dma_rdata = g_chan[1].rdata_reg;

  assign err       = err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected acks,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic [15:0] dma_rdata;
  logic        dma_ack;
  logic        err, mem_en, mem_we, mem_ready, owner;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  // Memory model: ready after wait_states cycles of mem_en, never while hang is set.
  int wait_states = 0;
  bit hang = 1'b0;
  int en_cycles = 0;
  always @(posedge clk) en_cycles <= mem_en ? en_cycles + 1 : 0;
  assign mem_ready = mem_en && !hang && (en_cycles == wait_states);
  assign mem_rdata = (mem_addr == 16'h0123) ? 16'hBEEF : (mem_addr ^ 16'h5A5A);

  int en_cnt = 0, err_cnt = 0, ack_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (err) err_cnt++;
    if (cpu_ack || dma_ack) ack_cnt++;
    if (mem_en && mem_we && mem_addr == 16'h0040 && mem_wdata == 16'h1234) wr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    bit          dma;
    logic [15:0] rdata;
    bit          err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (cpu_ack || dma_ack) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL ack_unexpected: got cpu_ack=%b dma_ack=%b expected no ack", cpu_ack, dma_ack);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %s ack rdata=%h err=%b", cpu_ack ? "cpu" : "dma",
                 cpu_ack ? cpu_rdata : dma_rdata, err);
        check("ack_src", 32'({cpu_ack, dma_ack}), mon_e.dma ? 32'h1 : 32'h2);
        check("ack_rdata", 32'(mon_e.dma ? dma_rdata : cpu_rdata), 32'(mon_e.rdata));
        check("ack_err", 32'(err), 32'(mon_e.err));
      end
    end else if (err) begin
      check_cnt++;
      $display("FAIL err_without_ack: got err=1 expected 0");
    end
  end

  task automatic push_exp(input bit dma, input logic [15:0] rdata, input bit e);
    exp_t x;
    x.dma = dma; x.rdata = rdata; x.err = e;
    exp_q.push_back(x);
  endtask

  // Called at a negedge; raises req, waits (bounded) for ack, drops req, idles one cycle.
  task automatic do_access(input bit dma, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat, output bit got);
    if (dma) begin dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1; end
    else     begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = dma ? dma_ack : cpu_ack;
    end
    if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic requester(input bit dma, input int n, input logic [15:0] base);
    int lat; bit got;
    for (int i = 0; i < n; i++) begin
      do_access(dma, 1'b0, base + 16'(i), 16'h0, lat, got);
      check(dma ? "dma_served" : "cpu_served", 32'(got), 32'h1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat; bit got;
    int en0, err0, ack0, wr0;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'h0);
    check("rst_acks", 32'({cpu_ack, dma_ack}), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_owner", 32'(owner), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_en", 32'(mem_en), 32'h0);
    end

    // CPU read, zero wait
    wait_states = 0;
    push_exp(1'b0, 16'hBEEF, 1'b0);
    do_access(1'b0, 1'b0, 16'h0123, 16'h0, lat, got);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_owner", 32'(owner), 32'h0);
    check("rd_addr_held", 32'(mem_addr), 32'h0123);

    // DMA write, 3 wait states
    wait_states = 3;
    en0 = en_cnt; wr0 = wr_cnt;
    push_exp(1'b1, 16'h0000, 1'b0);
    do_access(1'b1, 1'b1, 16'h0040, 16'h1234, lat, got);
    check("wr_latency", 32'(lat), 32'd5);
    check("wr_en_cycles", 32'(en_cnt - en0), 32'd4);
    check("wr_strobe_cycles", 32'(wr_cnt - wr0), 32'd4);
    check("wr_owner", 32'(owner), 32'h1);
    check("wr_mem_en_off", 32'(mem_en), 32'h0);

    // Contention: 4 accesses each, alternating starting with CPU
    wait_states = 0;
    push_exp(1'b0, 16'h5B5A, 1'b0); push_exp(1'b1, 16'h585A, 1'b0);
    push_exp(1'b0, 16'h5B5B, 1'b0); push_exp(1'b1, 16'h585B, 1'b0);
    push_exp(1'b0, 16'h5B58, 1'b0); push_exp(1'b1, 16'h5858, 1'b0);
    push_exp(1'b0, 16'h5B59, 1'b0); push_exp(1'b1, 16'h5859, 1'b0);
    fork
      requester(1'b0, 4, 16'h0100);
      requester(1'b1, 4, 16'h0200);
    join
    @(negedge clk);
    check("cont_owner", 32'(owner), 32'h1);

    // Timeout: memory never ready
    hang = 1'b1;
    en0 = en_cnt; err0 = err_cnt; ack0 = ack_cnt;
    push_exp(1'b0, 16'h5B59, 1'b1);
    do_access(1'b0, 1'b0, 16'h0777, 16'h0, lat, got);
    check("to_latency", 32'(lat), 32'd17);
    check("to_en_cycles", 32'(en_cnt - en0), 32'd16);
    check("to_err_pulses", 32'(err_cnt - err0), 32'd1);
    check("to_ack_pulses", 32'(ack_cnt - ack0), 32'd1);
    check("to_idle", 32'(mem_en), 32'h0);
    hang = 1'b0;

    // Reset during a DMA wait state
    wait_states = 10;
    ack0 = ack_cnt;
    dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 16'h5555; dma_req = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_pre_en", 32'(mem_en), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en_drop", 32'(mem_en), 32'h0);
    dma_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_ack", 32'(ack_cnt - ack0), 32'h0);
    check("mid_rst_owner", 32'(owner), 32'h1);
    wait_states = 0;
    push_exp(1'b0, 16'h5B5E, 1'b0);
    push_exp(1'b1, 16'h585E, 1'b0);
    fork
      requester(1'b0, 1, 16'h0104);
      requester(1'b1, 1, 16'h0204);
    join
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
